// File: rtl/exec_pkg.sv
// Shared opcode, ALU-op and branch-op encodings for the integer execute stage.
package exec_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned FUNC_W = 4;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OP_R  = 7'b0000001;
    localparam logic [OPC_W-1:0] OP_I  = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_BR = 7'b0001111;

    // func[3] is the funct7 modifier, func[2:0] is funct3
    typedef enum logic [FUNC_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b1000,
        ALU_AND = 4'b0111,
        ALU_OR  = 4'b0110,
        ALU_XOR = 4'b0100,
        ALU_SLL = 4'b0001,
        ALU_SRL = 4'b0101,
        ALU_SRA = 4'b1101
    } alu_op_e;

    typedef enum logic [FUNC_W-1:0] {
        BR_BEQ  = 4'b0000,
        BR_BNE  = 4'b0001,
        BR_BLT  = 4'b0100,
        BR_BGE  = 4'b0101,
        BR_BLTU = 4'b0110,
        BR_BGEU = 4'b0111
    } br_op_e;

    function automatic logic is_alu_func(input logic [FUNC_W-1:0] f);
        case (f)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
            ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA: is_alu_func = 1'b1;
            default:                            is_alu_func = 1'b0;
        endcase
    endfunction

    function automatic logic is_br_func(input logic [FUNC_W-1:0] f);
        case (f)
            BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: is_br_func = 1'b1;
            default:                                          is_br_func = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: operand A/B plus an alu_op_e select produce the result.
module alu_core
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD: result_c = a + b;
            ALU_SUB: result_c = a - b;
            ALU_AND: result_c = a & b;
            ALU_OR:  result_c = a | b;
            ALU_XOR: result_c = a ^ b;
            ALU_SLL: result_c = a << shamt;
            ALU_SRL: result_c = a >> shamt;
            ALU_SRA: result_c = XLEN'($signed(a) >>> shamt);
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/execute_unit.sv
// Integer execute stage: decode, ALU, branch compare, one cycle of output registers.
module execute_unit
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [6:0]      opcode,
    input  logic [3:0]      func,
    output logic [XLEN-1:0] sonuc,
    output logic            pc_update,
    output logic            we,
    output logic            hata
);

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    alu_op_e         alu_op;
    logic [XLEN-1:0] sonuc_n;
    logic            pc_update_n;
    logic            we_n;
    logic            hata_n;
    logic            taken;

    alu_core #(.XLEN(XLEN)) u_alu (
        .a        (rs1_data),
        .b        (op_b),
        .op       (alu_op),
        .result_c (alu_res)
    );

    // Branch condition evaluation
    always_comb begin
        taken = 1'b0;
        case (func)
            BR_BEQ:  taken = (rs1_data == rs2_data);
            BR_BNE:  taken = (rs1_data != rs2_data);
            BR_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
            BR_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
            BR_BLTU: taken = (rs1_data <  rs2_data);
            BR_BGEU: taken = (rs1_data >= rs2_data);
            default: taken = 1'b0;
        endcase
    end

    // Decode; illegal encodings fall through with everything cleared except hata
    always_comb begin
        op_b        = rs2_data;
        alu_op      = ALU_ADD;
        sonuc_n     = '0;
        pc_update_n = 1'b0;
        we_n        = 1'b0;
        hata_n      = 1'b0;
        case (opcode)
            OP_R: begin
                if (is_alu_func(func)) begin
                    alu_op  = alu_op_e'(func);
                    sonuc_n = alu_res;
                    we_n    = 1'b1;
                end else begin
                    hata_n = 1'b1;
                end
            end
            OP_I: begin
                op_b = imm;
                if (is_alu_func(func) && (func != ALU_SUB)) begin
                    alu_op  = alu_op_e'(func);
                    sonuc_n = alu_res;
                    we_n    = 1'b1;
                end else begin
                    hata_n = 1'b1;
                end
            end
            OP_BR: begin
                if (is_br_func(func)) begin
                    sonuc_n     = imm;
                    pc_update_n = taken;
                end else begin
                    hata_n = 1'b1;
                end
            end
            default: hata_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sonuc     <= '0;
            pc_update <= 1'b0;
            we        <= 1'b0;
            hata      <= 1'b0;
        end else begin
            sonuc     <= sonuc_n;
            pc_update <= pc_update_n;
            we        <= we_n;
            hata      <= hata_n;
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit with hand-computed expected values.
module tb_execute_unit;

    logic        clk;
    logic        rst;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [3:0]  func;
    logic [31:0] sonuc;
    logic        pc_update;
    logic        we;
    logic        hata;

    int checks;
    int failures;

    localparam logic [6:0] R   = 7'b0000001;
    localparam logic [6:0] I   = 7'b0000011;
    localparam logic [6:0] BR  = 7'b0001111;
    localparam logic [6:0] BAD = 7'b0000111;

    execute_unit dut (
        .clk       (clk),
        .rst       (rst),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
        .opcode    (opcode),
        .func      (func),
        .sonuc     (sonuc),
        .pc_update (pc_update),
        .we        (we),
        .hata      (hata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one op, clock it in, then compare all outputs 1 time unit after the edge
    task automatic step(input string tag, input logic [6:0] opc, input logic [3:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] exp_res, input logic exp_pc,
                        input logic exp_we, input logic exp_hata);
        opcode   = opc;
        func     = fn;
        rs1_data = a;
        rs2_data = b;
        imm      = im;
        @(posedge clk);
        #1;
        checks++;
        assert (sonuc === exp_res) else begin
            failures++;
            $error("FAIL %s sonuc got=%h exp=%h", tag, sonuc, exp_res);
        end
        checks++;
        assert (pc_update === exp_pc) else begin
            failures++;
            $error("FAIL %s pc_update got=%b exp=%b", tag, pc_update, exp_pc);
        end
        checks++;
        assert (we === exp_we) else begin
            failures++;
            $error("FAIL %s we got=%b exp=%b", tag, we, exp_we);
        end
        checks++;
        assert (hata === exp_hata) else begin
            failures++;
            $error("FAIL %s hata got=%b exp=%b", tag, hata, exp_hata);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        step("reset", R, 4'b0000, 32'd4, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // R-type, rs1=4 rs2=7
        step("add",  R, 4'b0000, 32'd4, 32'd7, 32'd0, 32'd11,        1'b0, 1'b1, 1'b0);
        step("sub",  R, 4'b1000, 32'd4, 32'd7, 32'd0, 32'hFFFFFFFD,  1'b0, 1'b1, 1'b0);
        step("and",  R, 4'b0111, 32'd4, 32'd7, 32'd0, 32'd4,         1'b0, 1'b1, 1'b0);
        step("or",   R, 4'b0110, 32'd4, 32'd7, 32'd0, 32'd7,         1'b0, 1'b1, 1'b0);
        // R-type, rs1=6 rs2=5
        step("xor",  R, 4'b0100, 32'd6, 32'd5, 32'd0, 32'd3,         1'b0, 1'b1, 1'b0);
        step("sll",  R, 4'b0001, 32'd6, 32'd5, 32'd0, 32'd192,       1'b0, 1'b1, 1'b0);
        step("srl",  R, 4'b0101, 32'd6, 32'd5, 32'd0, 32'd0,         1'b0, 1'b1, 1'b0);
        step("sra",  R, 4'b1101, 32'd6, 32'd5, 32'd0, 32'd0,         1'b0, 1'b1, 1'b0);
        step("sra_neg", R, 4'b1101, 32'h80000000, 32'd4, 32'd0, 32'hF8000000, 1'b0, 1'b1, 1'b0);
        step("srl_neg", R, 4'b0101, 32'h80000000, 32'd4, 32'd0, 32'h08000000, 1'b0, 1'b1, 1'b0);
        step("r_badfn", R, 4'b0010, 32'd4, 32'd7, 32'd0, 32'd0,     1'b0, 1'b0, 1'b1);

        // I-type, imm=2 (rs2 deliberately differs to catch a wrong operand mux)
        step("addi", I, 4'b0000, 32'd6,  32'd99, 32'd2, 32'd8,   1'b0, 1'b1, 1'b0);
        step("andi", I, 4'b0111, 32'd6,  32'd99, 32'd2, 32'd2,   1'b0, 1'b1, 1'b0);
        step("ori",  I, 4'b0110, 32'd6,  32'd99, 32'd2, 32'd6,   1'b0, 1'b1, 1'b0);
        step("xori", I, 4'b0100, 32'd28, 32'd99, 32'd2, 32'd30,  1'b0, 1'b1, 1'b0);
        step("slli", I, 4'b0001, 32'd28, 32'd99, 32'd2, 32'd112, 1'b0, 1'b1, 1'b0);
        step("srli", I, 4'b0101, 32'd28, 32'd99, 32'd2, 32'd7,   1'b0, 1'b1, 1'b0);
        step("i_sub", I, 4'b1000, 32'd28, 32'd99, 32'd2, 32'd0,  1'b0, 1'b0, 1'b1);

        // Branches, imm=2
        step("br_0011", BR, 4'b0011, 32'd28, 32'd3, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1);
        step("br_1000", BR, 4'b1000, 32'd28, 32'd3, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1);
        step("beq_nt",  BR, 4'b0000, 32'd28, 32'd3, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        step("beq_t",   BR, 4'b0000, 32'd28, 32'd28, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0);
        step("bne",     BR, 4'b0001, 32'd0,  32'd16, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0);
        step("blt",     BR, 4'b0100, 32'd0,  32'd16, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0);
        step("bge",     BR, 4'b0101, 32'd24, 32'd10, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0);
        step("bltu",    BR, 4'b0110, 32'd24, 32'd10, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        step("bgeu",    BR, 4'b0111, 32'd30, 32'd21, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0);
        step("blt_neg", BR, 4'b0100, 32'hFFFFFFFF, 32'd1, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0);
        step("bltu_big", BR, 4'b0110, 32'hFFFFFFFF, 32'd1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        step("bge_neg", BR, 4'b0101, 32'hFFFFFFFF, 32'd1, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        step("bgeu_big", BR, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0);

        // Illegal opcode, then a legal op clears hata
        step("bad_opc", BAD, 4'b0000, 32'd4, 32'd7, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1);
        step("after_bad", R, 4'b0000, 32'd4, 32'd7, 32'd0, 32'd11, 1'b0, 1'b1, 1'b0);

        // Reset mid-stream overrides the driven op
        step("pre_rst", R, 4'b1000, 32'd4, 32'd7, 32'd0, 32'hFFFFFFFD, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step("mid_rst", R, 4'b0000, 32'd4, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("post_rst", R, 4'b0000, 32'd4, 32'd7, 32'd0, 32'd11, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- Integer execute stage (ALU plus branch comparator) of the single-cycle RV-style processor.
- Decodes a 7-bit opcode and a 4-bit func code (func[3] is the funct7 modifier bit, func[2:0] is funct3).
- Computes an R-type, I-type or branch result and flags the branch decision, register write enable and illegal instructions.
- Outputs are registered: one clock of latency to the writeback and PC logic.

Parameters:
- XLEN, 32, datapath width; shift amounts use the low log2(XLEN) bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1_data  input  XLEN  source operand 1.
- rs2_data  input  XLEN  source operand 2.
- imm  input  XLEN  sign-extended immediate, already produced by decode.
- opcode  input  7  instruction class.
- func  input  4  operation select.
- sonuc  output  XLEN  result.
- pc_update  output  1  branch taken.
- we  output  1  register file write enable.
- hata  output  1  illegal opcode/func.

Behaviour:
- Latency and reset:
  - Combinational decode and compute; all four outputs are registered on the rising clk.
  - Inputs sampled at edge N appear on outputs after edge N.
  - With rst=1 at an edge, sonuc=0 and pc_update=we=hata=0. rst overrides any input, including mid-stream.
- Opcode 7'b0000001, R-type, operand B = rs2_data, we=1:
  - 0000 ADD; 1000 SUB; 0111 AND; 0110 OR; 0100 XOR.
  - 0001 SLL; 0101 SRL (logical); 1101 SRA (arithmetic).
  - Shift amount is B[4:0].
- Opcode 7'b0000011, I-type, operand B = imm, we=1:
  - Same encodings as R-type except SUB: 1000 is illegal.
  - Valid funcs: 0000 ADDI, 0111, 0110, 0100, 0001, 0101, 1101.
- Opcode 7'b0001111, branch, we=0, sonuc=imm (branch offset passed through):
  - 0000 BEQ (rs1==rs2); 0001 BNE; 0100 BLT (signed <); 0101 BGE (signed >=); 0110 BLTU; 0111 BGEU.
  - pc_update=1 iff the condition holds.
  - func[3]=1, 0010 and 0011 are illegal.
- Arithmetic: add/sub wrap modulo 2^32, with no overflow flag. Signed compare and SRA use two's complement.
- Illegal case: any other opcode (e.g. 7'b0000111) or any unlisted func.
  - hata=1, sonuc=0, we=0, pc_update=0.
- For legal non-branch ops, pc_update=0 and hata=0.
- Inputs changing every cycle is legal. No handshake: one op per cycle, always accepted.

Decomposition:
- Shared package exec_pkg holds:
  - opcode localparams OP_R=7'b0000001, OP_I=7'b0000011, OP_BR=7'b0001111;
  - func encodings as an enum alu_op_e (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA);
  - branch encodings as br_op_e (BEQ, BNE, BLT, BGE, BLTU, BGEU).
- One natural sub-module, alu_core: pure combinational operand-A/B plus alu_op_e producing the result. Decode, branch compare and output registers live in execute_unit.

Test Plan:
- R-type, rs1=4 and rs2=7, one op per cycle:
  - ADD→11, SUB→0xFFFFFFFD, AND→4, OR→7.
  - Each with we=1, hata=0, pc_update=0, valid one clock after apply.
- R-type, rs1=6 and rs2=5: XOR→3, SLL→192, SRL→0, SRA→0. Then rs1=0x80000000, rs2=4, SRA→0xF8000000.
- I-type, imm=2:
  - rs1=6: ADDI→8, ANDI→2, ORI→6.
  - rs1=28: XORI→30, SLLI→112, SRLI→7.
  - func 1000 → hata=1, we=0, sonuc=0.
- Branch, imm=2, we=0, sonuc=2 on every legal branch:
  - rs1=28, rs2=3: func 0011 → hata=1; BEQ → pc_update=0.
  - rs1=0, rs2=16: BNE→1, BLT→1.
  - rs1=24, rs2=10: BGE→1, BLTU→0.
  - rs1=30, rs2=21: BGEU→1.
  - rs1=0xFFFFFFFF, rs2=1: BLT→1, BLTU→0.
- Opcode 7'b0000111 for one cycle → hata=1, we=0, pc_update=0, sonuc=0; the next legal op clears hata.
- rst asserted while ADD 4+7 is driven → outputs all 0 that cycle. Release → 11 appears after the next edge.
